// File: rtl/spi_msg_sequencer_if.sv
// Bus bundle between the QSPI pin logic, the message consumer and the
// streaming data source. The sequencer uses the slave view; the host side
// (pins plus data source) uses the master view.
interface spi_msg_sequencer_if;
  logic        spi_cs;      // active-high select, synchronous to spi_clk
  logic [3:0]  din;         // registered spi_d[3:0] input nibble
  logic [7:0]  dout;        // [7:4] hi-byte nibble lane, [3:0] lo-byte nibble lane
  logic        dout_en;     // spi_d output enable
  logic        msg_valid;   // one-cycle pulse, msg_type/msg_arg valid
  logic [7:0]  msg_type;    // message bits [63:56]
  logic [55:0] msg_arg;     // message bits [55:0]
  logic        msg_err;     // one-cycle pulse, unknown message type
  logic        data_ready;  // sequencer takes a word on this edge if data_valid
  logic        data_valid;  // stream word available
  logic [15:0] data;        // stream word
  logic        underrun;    // sticky until cs drops: a stream slot found no word

  modport master (
    output spi_cs, din, data_valid, data,
    input  dout, dout_en, msg_valid, msg_type, msg_arg, msg_err, data_ready, underrun
  );

  modport slave (
    input  spi_cs, din, data_valid, data,
    output dout, dout_en, msg_valid, msg_type, msg_arg, msg_err, data_ready, underrun
  );
endinterface

// File: rtl/spi_msg_sequencer.sv
// QSPI message sequencer. One transaction per spi_cs assertion:
//   dummy edges -> 64-bit message in 4-bit nibbles -> type decode during the
//   turnaround -> response (echo of the argument, a 16-bit data stream, or
//   nothing). Every output is a register so the pad logic sees clean timing.
// Response words are 16 bits and take two edges each: slot A carries the
// high nibble of each byte, slot B the low nibble, on the two byte lanes.
module spi_msg_sequencer #(
  parameter int unsigned MsgLen      = 64,
  parameter int unsigned DummyCycles = 2,
  parameter int unsigned TurnCycles  = 4
) (
  input  logic                spi_clk,
  input  logic                spi_rst_,
  spi_msg_sequencer_if.slave  bus
);

  // Edge counter covers the longer of the message phase and the turnaround.
  localparam int unsigned NibbleCount = MsgLen / 4;
  localparam int unsigned CntMax      = (NibbleCount > TurnCycles) ? NibbleCount : TurnCycles;
  localparam int unsigned CntWidth    = $clog2(CntMax + 1);

  localparam logic [CntWidth-1:0] LastDummy  = CntWidth'(DummyCycles - 1);
  localparam logic [CntWidth-1:0] LastNibble = CntWidth'(NibbleCount - 1);
  localparam logic [CntWidth-1:0] LastTurn   = CntWidth'(TurnCycles - 1);
  // The stream source is asked for word 0 one edge before the first slot.
  localparam logic [CntWidth-1:0] PrepTurn   = CntWidth'(TurnCycles - 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DUMMY,
    ST_RECV,
    ST_TURN,
    ST_ECHO,
    ST_STREAM,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    KIND_ECHO,
    KIND_READ,
    KIND_NOOP,
    KIND_ERR
  } kind_e;

  // Slot A: high nibble of each byte of the word.
  function automatic logic [7:0] slot_a(input logic [15:0] w);
    slot_a = {w[15:12], w[7:4]};
  endfunction

  // Slot B: low nibble of each byte of the word.
  function automatic logic [7:0] slot_b(input logic [15:0] w);
    slot_b = {w[11:8], w[3:0]};
  endfunction

  // Message type to response kind; anything unlisted is an error.
  function automatic kind_e decode_type(input logic [7:0] typ);
    case (typ)
      8'h00:   decode_type = KIND_ECHO;
      8'h01:   decode_type = KIND_READ;
      8'hFF:   decode_type = KIND_NOOP;
      default: decode_type = KIND_ERR;
    endcase
  endfunction

  state_e                state_r;
  kind_e                 kind_r;
  logic [CntWidth-1:0]   cnt_r;
  logic [MsgLen-1:0]     shift_r;     // message in RECV, echo words afterwards
  logic [15:0]           word_r;      // stream word currently on the bus
  logic                  slot_b_r;    // next response edge drives slot B
  logic [7:0]            dout_r;
  logic                  dout_en_r;
  logic                  msg_valid_r;
  logic [7:0]            msg_type_r;
  logic [55:0]           msg_arg_r;
  logic                  msg_err_r;
  logic                  data_ready_r;
  logic                  underrun_r;

  logic [MsgLen-1:0]     msg_next_s;
  logic [15:0]           echo_word_s;
  logic [15:0]           fetch_word_s;
  kind_e                 kind_next_s;

  // Next message value, current echo word and the word a stream slot fetches.
  always_comb begin
    msg_next_s  = {shift_r[MsgLen-5:0], bus.din};
    echo_word_s = shift_r[MsgLen-1 -: 16];
    kind_next_s = decode_type(msg_next_s[MsgLen-1 -: 8]);
    if (bus.data_valid) begin
      fetch_word_s = bus.data;
    end else begin
      fetch_word_s = 16'hFFFF;
    end
  end

  // Transaction sequencer: state, counters, shift register and all outputs.
  always_ff @(posedge spi_clk or negedge spi_rst_) begin
    if (!spi_rst_) begin
      state_r      <= ST_IDLE;
      kind_r       <= KIND_NOOP;
      cnt_r        <= '0;
      shift_r      <= '0;
      word_r       <= 16'hFFFF;
      slot_b_r     <= 1'b0;
      dout_r       <= 8'hFF;
      dout_en_r    <= 1'b0;
      msg_valid_r  <= 1'b0;
      msg_type_r   <= 8'h00;
      msg_arg_r    <= 56'h0;
      msg_err_r    <= 1'b0;
      data_ready_r <= 1'b0;
      underrun_r   <= 1'b0;
    end else if (!bus.spi_cs) begin
      // Deselect aborts from any state; the last decoded message is kept.
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      slot_b_r     <= 1'b0;
      dout_r       <= 8'hFF;
      dout_en_r    <= 1'b0;
      msg_valid_r  <= 1'b0;
      msg_err_r    <= 1'b0;
      data_ready_r <= 1'b0;
      underrun_r   <= 1'b0;
    end else begin
      msg_valid_r <= 1'b0;
      msg_err_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // This edge is already dummy edge 1.
          if (DummyCycles <= 1) begin
            state_r <= ST_RECV;
            cnt_r   <= '0;
          end else begin
            state_r <= ST_DUMMY;
            cnt_r   <= CntWidth'(1);
          end
        end

        ST_DUMMY: begin
          if (cnt_r == LastDummy) begin
            state_r <= ST_RECV;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CntWidth'(1);
          end
        end

        ST_RECV: begin
          shift_r <= msg_next_s;
          if (cnt_r == LastNibble) begin
            state_r     <= ST_TURN;
            cnt_r       <= '0;
            msg_type_r  <= msg_next_s[MsgLen-1 -: 8];
            msg_arg_r   <= msg_next_s[MsgLen-9 -: 56];
            msg_valid_r <= 1'b1;
            kind_r      <= kind_next_s;
            msg_err_r   <= (kind_next_s == KIND_ERR);
          end else begin
            cnt_r <= cnt_r + CntWidth'(1);
          end
        end

        ST_TURN: begin
          // Drop the type byte and pad with 8'hFF: the register now holds the echo words.
          if (cnt_r == '0) begin
            shift_r <= {shift_r[MsgLen-9:0], 8'hFF};
          end
          if ((kind_r == KIND_READ) && (cnt_r == PrepTurn)) begin
            data_ready_r <= 1'b1;
          end
          if (cnt_r == LastTurn) begin
            case (kind_r)
              KIND_ECHO: begin
                state_r   <= ST_ECHO;
                dout_en_r <= 1'b1;
                dout_r    <= slot_a(echo_word_s);
                slot_b_r  <= 1'b1;
              end
              KIND_READ: begin
                state_r      <= ST_STREAM;
                dout_en_r    <= 1'b1;
                word_r       <= fetch_word_s;
                dout_r       <= slot_a(fetch_word_s);
                underrun_r   <= underrun_r | ~bus.data_valid;
                data_ready_r <= 1'b0;
                slot_b_r     <= 1'b1;
              end
              default: begin
                state_r <= ST_DONE;
              end
            endcase
          end else begin
            cnt_r <= cnt_r + CntWidth'(1);
          end
        end

        ST_ECHO: begin
          // After the four message words the fill is all ones; no wrap.
          if (slot_b_r) begin
            dout_r   <= slot_b(echo_word_s);
            shift_r  <= {shift_r[MsgLen-17:0], 16'hFFFF};
            slot_b_r <= 1'b0;
          end else begin
            dout_r   <= slot_a(echo_word_s);
            slot_b_r <= 1'b1;
          end
        end

        ST_STREAM: begin
          // Ready is raised during slot B so the next word lands in slot A.
          if (slot_b_r) begin
            dout_r       <= slot_b(word_r);
            data_ready_r <= 1'b1;
            slot_b_r     <= 1'b0;
          end else begin
            word_r       <= fetch_word_s;
            dout_r       <= slot_a(fetch_word_s);
            underrun_r   <= underrun_r | ~bus.data_valid;
            data_ready_r <= 1'b0;
            slot_b_r     <= 1'b1;
          end
        end

        ST_DONE: begin
          dout_r    <= 8'hFF;
          dout_en_r <= 1'b0;
        end

        default: begin
          state_r      <= ST_IDLE;
          dout_r       <= 8'hFF;
          dout_en_r    <= 1'b0;
          data_ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout       = dout_r;
  assign bus.dout_en    = dout_en_r;
  assign bus.msg_valid  = msg_valid_r;
  assign bus.msg_type   = msg_type_r;
  assign bus.msg_arg    = msg_arg_r;
  assign bus.msg_err    = msg_err_r;
  assign bus.data_ready = data_ready_r;
  assign bus.underrun   = underrun_r;

endmodule

// File: tb/tb_spi_msg_sequencer.sv
// Directed bench for spi_msg_sequencer. Inputs change 1 ns after each rising
// edge and outputs are sampled at the same point, so "after edge N" below
// means the registered value the host sees at edge N+1.
module tb_spi_msg_sequencer;
  logic spi_clk = 1'b0;
  logic spi_rst_;

  spi_msg_sequencer_if bus();

  int n_vec    = 0;
  int n_err    = 0;
  int mv_cnt   = 0;
  int me_cnt   = 0;
  int src_idx  = 0;
  int src_base = 0;

  spi_msg_sequencer #(
    .MsgLen      (64),
    .DummyCycles (2),
    .TurnCycles  (4)
  ) dut (
    .spi_clk  (spi_clk),
    .spi_rst_ (spi_rst_),
    .bus      (bus)
  );

  always #5 spi_clk = ~spi_clk;

  // Pulse counters and the streaming source (word value = words taken so far).
  always @(posedge spi_clk) begin
    if (bus.msg_valid === 1'b1) mv_cnt <= mv_cnt + 1;
    if (bus.msg_err === 1'b1) me_cnt <= me_cnt + 1;
    if (bus.data_ready === 1'b1 && bus.data_valid === 1'b1) src_idx <= src_idx + 1;
  end

  assign bus.data = 16'(src_idx - src_base);

  task automatic step(input logic cs, input logic [3:0] d);
    bus.spi_cs = cs;
    bus.din    = d;
    @(posedge spi_clk);
    #1;
  endtask

  // Edges 1..18: two dummies then 16 nibbles, cs held high.
  task automatic send_header(input logic [63:0] msg);
    step(1'b1, 4'h5);
    step(1'b1, 4'hA);
    for (int i = 0; i < 16; i++) step(1'b1, msg[63-4*i -: 4]);
  endtask

  task automatic test_reset;
    spi_rst_ = 1'b0;
    bus.spi_cs = 1'b0;
    bus.din = 4'h0;
    bus.data_valid = 1'b1;
    repeat (2) @(posedge spi_clk);
    #1;
    n_vec++; if (bus.dout !== 8'hFF) begin n_err++; $display("FAIL rst_dout got %h want ff", bus.dout); end
    n_vec++; if (bus.dout_en !== 1'b0) begin n_err++; $display("FAIL rst_dout_en got %b want 0", bus.dout_en); end
    n_vec++; if ({bus.msg_valid, bus.msg_err, bus.data_ready, bus.underrun} !== 4'b0000) begin
      n_err++; $display("FAIL rst_flags got %b want 0000", {bus.msg_valid, bus.msg_err, bus.data_ready, bus.underrun});
    end
    n_vec++; if ({bus.msg_type, bus.msg_arg} !== 64'h0) begin
      n_err++; $display("FAIL rst_msg got %h want 0", {bus.msg_type, bus.msg_arg});
    end
    @(negedge spi_clk);
    spi_rst_ = 1'b1;
    step(1'b0, 4'h0);
    n_vec++; if (bus.dout_en !== 1'b0 || bus.dout !== 8'hFF) begin
      n_err++; $display("FAIL idle_bus got en=%b dout=%h want en=0 dout=ff", bus.dout_en, bus.dout);
    end
  endtask

  task automatic test_echo(input logic [55:0] arg);
    logic [63:0] msg;
    logic [63:0] exp;
    logic [63:0] got;
    logic [7:0]  sa;
    logic [7:0]  sb;
    int          base;
    msg  = {8'h00, arg};
    exp  = {arg, 8'hFF};
    base = mv_cnt;
    send_header(msg);
    step(1'b1, 4'h0); step(1'b1, 4'h0); step(1'b1, 4'h0);     // edges 19..21
    n_vec++; if (bus.dout_en !== 1'b0) begin n_err++; $display("FAIL echo_en_early got %b want 0", bus.dout_en); end
    step(1'b1, 4'h0);                                          // edge 22
    n_vec++; if (bus.dout_en !== 1'b1) begin n_err++; $display("FAIL echo_en_edge22 got %b want 1", bus.dout_en); end
    got = 64'h0;
    for (int w = 0; w < 4; w++) begin
      sa = bus.dout;
      step(1'b1, 4'h0);
      sb = bus.dout;
      got = {got[47:0], sa[7:4], sb[7:4], sa[3:0], sb[3:0]};
      if (w < 3) step(1'b1, 4'h0);
    end
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL echo_words got %h want %h", got, exp); end
    step(1'b1, 4'h0);
    sa = bus.dout;
    step(1'b1, 4'h0);
    sb = bus.dout;
    n_vec++; if ({sa, sb} !== 16'hFFFF) begin n_err++; $display("FAIL echo_fill got %h want ffff", {sa, sb}); end
    step(1'b0, 4'h0);
    n_vec++; if (bus.dout_en !== 1'b0 || bus.dout !== 8'hFF) begin
      n_err++; $display("FAIL echo_release got en=%b dout=%h want en=0 dout=ff", bus.dout_en, bus.dout);
    end
    n_vec++; if (mv_cnt - base != 1) begin n_err++; $display("FAIL echo_valid_pulses got %0d want 1", mv_cnt - base); end
    n_vec++; if (bus.msg_type !== 8'h00 || bus.msg_arg !== arg) begin
      n_err++; $display("FAIL echo_msg got %h_%h want 00_%h", bus.msg_type, bus.msg_arg, arg);
    end
  endtask

  task automatic test_read_data(input logic stall);
    logic [63:0] exp;
    logic [63:0] got;
    logic [7:0]  sa;
    logic [7:0]  sb;
    int          exp_taken;
    exp       = stall ? 64'h0000_FFFF_0001_0002 : 64'h0000_0001_0002_0003;
    exp_taken = stall ? 3 : 4;
    src_base  = src_idx;
    bus.data_valid = 1'b1;
    send_header({8'h01, 56'h0});
    step(1'b1, 4'h0); step(1'b1, 4'h0);                        // edges 19,20
    n_vec++; if (bus.data_ready !== 1'b0) begin n_err++; $display("FAIL rd_ready_early got %b want 0", bus.data_ready); end
    step(1'b1, 4'h0);                                          // edge 21
    n_vec++; if (bus.data_ready !== 1'b1) begin n_err++; $display("FAIL rd_ready_turn got %b want 1", bus.data_ready); end
    step(1'b1, 4'h0);                                          // edge 22
    n_vec++; if (bus.dout_en !== 1'b1 || bus.data_ready !== 1'b0) begin
      n_err++; $display("FAIL rd_slot0 got en=%b rdy=%b want en=1 rdy=0", bus.dout_en, bus.data_ready);
    end
    got = 64'h0;
    for (int w = 0; w < 4; w++) begin
      sa = bus.dout;
      step(1'b1, 4'h0);
      sb = bus.dout;
      if (w == 0) begin
        n_vec++; if (bus.data_ready !== 1'b1) begin n_err++; $display("FAIL rd_ready_slotb got %b want 1", bus.data_ready); end
      end
      got = {got[47:0], sa[7:4], sb[7:4], sa[3:0], sb[3:0]};
      if (w < 3) begin
        bus.data_valid = !(stall && w == 0);
        step(1'b1, 4'h0);
        bus.data_valid = 1'b1;
      end
    end
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL rd_words got %h want %h", got, exp); end
    n_vec++; if (bus.underrun !== stall) begin n_err++; $display("FAIL rd_underrun got %b want %b", bus.underrun, stall); end
    n_vec++; if (src_idx - src_base != exp_taken) begin
      n_err++; $display("FAIL rd_taken got %0d want %0d", src_idx - src_base, exp_taken);
    end
    bus.data_valid = 1'b0;
    step(1'b0, 4'h0);
    bus.data_valid = 1'b1;
    n_vec++; if ({bus.underrun, bus.dout_en, bus.data_ready} !== 3'b000) begin
      n_err++; $display("FAIL rd_release got %b want 000", {bus.underrun, bus.dout_en, bus.data_ready});
    end
  endtask

  task automatic test_noop(input logic [7:0] typ, input int exp_err);
    int bm;
    int be;
    int bad;
    bm  = mv_cnt;
    be  = me_cnt;
    bad = 0;
    send_header({typ, 56'h11223344556677});
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 4'h0);
      if (bus.dout_en !== 1'b0 || bus.dout !== 8'hFF || bus.data_ready !== 1'b0) bad++;
    end
    step(1'b0, 4'h0);
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL noop_bus_%h got %0d driven edges want 0", typ, bad); end
    n_vec++; if (mv_cnt - bm != 1) begin n_err++; $display("FAIL noop_valid_%h got %0d want 1", typ, mv_cnt - bm); end
    n_vec++; if (me_cnt - be != exp_err) begin n_err++; $display("FAIL noop_err_%h got %0d want %0d", typ, me_cnt - be, exp_err); end
    n_vec++; if (bus.msg_type !== typ || bus.msg_arg !== 56'h11223344556677) begin
      n_err++; $display("FAIL noop_msg_%h got %h_%h want %h_11223344556677", typ, bus.msg_type, bus.msg_arg, typ);
    end
  endtask

  task automatic test_abort;
    logic [63:0] msg;
    int          base;
    msg  = {8'h00, 56'h123456789ABCDE};
    base = mv_cnt;
    step(1'b1, 4'h0); step(1'b1, 4'h0);
    for (int i = 0; i < 8; i++) step(1'b1, msg[63-4*i -: 4]);
    step(1'b0, 4'h0);
    n_vec++; if (bus.dout_en !== 1'b0 || bus.dout !== 8'hFF) begin
      n_err++; $display("FAIL abort_mid got en=%b dout=%h want en=0 dout=ff", bus.dout_en, bus.dout);
    end
    step(1'b0, 4'h0);
    // Deselect on the very edge that carries the last nibble.
    step(1'b1, 4'h0); step(1'b1, 4'h0);
    for (int i = 0; i < 15; i++) step(1'b1, msg[63-4*i -: 4]);
    step(1'b0, msg[3:0]);
    step(1'b0, 4'h0);
    n_vec++; if (mv_cnt - base != 0) begin n_err++; $display("FAIL abort_valid got %0d pulses want 0", mv_cnt - base); end
    test_echo(56'hA5A5A5A5A5A5A5);
  endtask

  task automatic test_async_reset;
    src_base = src_idx;
    bus.data_valid = 1'b1;
    send_header({8'h01, 56'h0});
    repeat (7) step(1'b1, 4'h0);                               // edge 25, mid-stream
    n_vec++; if (bus.dout_en !== 1'b1 || bus.msg_type !== 8'h01) begin
      n_err++; $display("FAIL arst_pre got en=%b type=%h want en=1 type=01", bus.dout_en, bus.msg_type);
    end
    spi_rst_ = 1'b0;
    #2;
    n_vec++; if ({bus.dout, bus.dout_en, bus.data_ready, bus.underrun, bus.msg_valid} !== {8'hFF, 4'b0000}) begin
      n_err++; $display("FAIL arst_outputs got dout=%h en=%b rdy=%b und=%b want dout=ff en=0 rdy=0 und=0",
                        bus.dout, bus.dout_en, bus.data_ready, bus.underrun);
    end
    n_vec++; if (bus.msg_type !== 8'h00) begin n_err++; $display("FAIL arst_type got %h want 00", bus.msg_type); end
    bus.spi_cs = 1'b0;
    @(negedge spi_clk);
    spi_rst_ = 1'b1;
    step(1'b0, 4'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_echo(56'h123456789ABCDE);
    test_read_data(1'b0);
    test_read_data(1'b1);
    test_noop(8'hFF, 0);
    test_noop(8'h37, 1);
    test_abort();
    test_async_reset();
    test_echo(56'h0F1E2D3C4B5A69);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
